// File: rtl/io_vga_pkg.sv
// Shared definitions for the VGA drawing engine.
// Contents: resolution defaults, swap address, register offsets, command
// codes, the coordinate type, the engine state enum and the framebuffer
// address packing helper.
package io_vga_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    localparam logic [23:0] SWAP_ADDR = 24'hfffffc;

    // Register window offsets
    localparam logic [1:0] REG_P0    = 2'd0;
    localparam logic [1:0] REG_P1    = 2'd1;
    localparam logic [1:0] REG_COLOR = 2'd2;
    localparam logic [1:0] REG_CMD   = 2'd3;

    // Command codes written to REG_CMD
    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_LINE = 2'd1;
    localparam logic [1:0] CMD_RECT = 2'd2;
    localparam logic [1:0] CMD_SWAP = 2'd3;

    // Signed coordinate / error arithmetic width
    localparam int COORD_W = 12;
    typedef logic signed [COORD_W-1:0] coord_t;

    localparam coord_t COORD_ZERO = 12'sd0;
    localparam coord_t COORD_ONE  = 12'sd1;
    localparam coord_t COORD_NEG1 = -12'sd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LINE  = 3'd2,
        ST_RECT  = 3'd3,
        ST_SWAP  = 3'd4
    } state_t;

    // Framebuffer pixel address: {4'h0, y, x}
    function automatic logic [23:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        return {4'h0, y, x};
    endfunction

endpackage

// File: rtl/io_vga_line_step.sv
// Pure-combinational Bresenham step.
// Inputs : current cursor (x, y), error term err, line constants dx, dy
//          (dy is negative), step directions sx/sy (+1/-1), end point.
// Outputs: next cursor and error, and last = cursor already at end point.
module io_vga_line_step
    import io_vga_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    input  coord_t err,
    input  coord_t dx,
    input  coord_t dy,
    input  coord_t sx,
    input  coord_t sy,
    input  coord_t x_end,
    input  coord_t y_end,
    output coord_t x_nxt,
    output coord_t y_nxt,
    output coord_t err_nxt,
    output logic   last
);

    // e2 = 2*err needs one extra bit so it cannot wrap
    logic signed [COORD_W:0] e2_s;
    logic signed [COORD_W:0] dx_w_s;
    logic signed [COORD_W:0] dy_w_s;
    logic                    step_x_s;
    logic                    step_y_s;

    assign e2_s     = {err, 1'b0};
    assign dx_w_s   = {dx[COORD_W-1], dx};
    assign dy_w_s   = {dy[COORD_W-1], dy};
    assign step_x_s = (e2_s >= dy_w_s);
    assign step_y_s = (e2_s <= dx_w_s);
    assign last     = (x == x_end) && (y == y_end);

    // Both axis decisions are taken from the pre-step error term
    always_comb begin
        x_nxt   = x;
        y_nxt   = y;
        err_nxt = err;
        if (step_x_s && step_y_s) begin
            x_nxt   = x + sx;
            y_nxt   = y + sy;
            err_nxt = err + dy + dx;
        end else if (step_x_s) begin
            x_nxt   = x + sx;
            err_nxt = err + dy;
        end else if (step_y_s) begin
            y_nxt   = y + sy;
            err_nxt = err + dx;
        end else begin
            err_nxt = err;
        end
    end

endmodule

// File: rtl/io_vga_draw.sv
// VGA drawing engine: CPU-programmed line / filled-rectangle / buffer-swap
// generator emitting single-pixel framebuffer writes under a ready handshake.
// Ports: clk, resetn (async, active-low); register window reg_addr/reg_wdata/
// reg_we/reg_rdata (P0, P1, COLOR, CMD/STATUS); pixel write stream
// pix_addr/pix_data/pix_we with pix_ready grant; busy.
module io_vga_draw
    import io_vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_we,
    output logic [31:0] reg_rdata,
    output logic [23:0] pix_addr,
    output logic [31:0] pix_data,
    output logic        pix_we,
    input  logic        pix_ready,
    output logic        busy
);

    localparam coord_t H_LIM = COORD_W'(H_RES);
    localparam coord_t V_LIM = COORD_W'(V_RES);

    state_t      state_r, state_nxt_s;
    logic [31:0] p0_r, p1_r, color_r;
    logic [1:0]  cmd_r;
    logic        overrun_r;
    coord_t      x_r, y_r, err_r, dx_r, dy_r, sx_r, sy_r, xe_r, ye_r, xmin_r;
    coord_t      x_nxt_s, y_nxt_s, err_nxt_s, dx_nxt_s, dy_nxt_s;
    coord_t      sx_nxt_s, sy_nxt_s, xe_nxt_s, ye_nxt_s, xmin_nxt_s;
    logic        pix_we_r, pix_we_nxt_s, busy_r, busy_nxt_s;
    logic [23:0] pix_addr_r, pix_addr_nxt_s;
    logic [31:0] pix_data_r, pix_data_nxt_s;
    coord_t      x0_s, y0_s, x1_s, y1_s, adx_s, ady_s, xmin_s, xmax_s, ymin_s, ymax_s;
    coord_t      step_x_s, step_y_s, step_err_s;
    logic        line_last_s, rect_last_s, advance_s, accept_s;

    function automatic logic on_screen(input coord_t x, input coord_t y);
        return (x >= COORD_ZERO) && (y >= COORD_ZERO) && (x < H_LIM) && (y < V_LIM);
    endfunction

    assign x0_s   = {2'b00, p0_r[9:0]};
    assign y0_s   = {2'b00, p0_r[19:10]};
    assign x1_s   = {2'b00, p1_r[9:0]};
    assign y1_s   = {2'b00, p1_r[19:10]};
    assign adx_s  = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
    assign ady_s  = (y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);
    assign xmin_s = (x0_s < x1_s) ? x0_s : x1_s;
    assign xmax_s = (x0_s < x1_s) ? x1_s : x0_s;
    assign ymin_s = (y0_s < y1_s) ? y0_s : y1_s;
    assign ymax_s = (y0_s < y1_s) ? y1_s : y0_s;

    // A pixel slot retires when accepted, or immediately when it was clipped
    assign advance_s   = ~pix_we_r | pix_ready;
    assign accept_s    = reg_we && (reg_addr == REG_CMD) && (state_r == ST_IDLE) &&
                         (reg_wdata[1:0] != CMD_NOP);
    assign rect_last_s = (x_r == xe_r) && (y_r == ye_r);

    io_vga_line_step u_line_step (
        .x       (x_r),
        .y       (y_r),
        .err     (err_r),
        .dx      (dx_r),
        .dy      (dy_r),
        .sx      (sx_r),
        .sy      (sy_r),
        .x_end   (xe_r),
        .y_end   (ye_r),
        .x_nxt   (step_x_s),
        .y_nxt   (step_y_s),
        .err_nxt (step_err_s),
        .last    (line_last_s)
    );

    // Register window: P0/P1/COLOR/CMD writable only when idle, overrun sticky
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p0_r      <= 32'h0;
            p1_r      <= 32'h0;
            color_r   <= 32'h0;
            cmd_r     <= CMD_NOP;
            overrun_r <= 1'b0;
        end else if (reg_we && (state_r == ST_IDLE)) begin
            case (reg_addr)
                REG_P0:    p0_r    <= reg_wdata;
                REG_P1:    p1_r    <= reg_wdata;
                REG_COLOR: color_r <= reg_wdata;
                REG_CMD: begin
                    if (accept_s) begin
                        cmd_r     <= reg_wdata[1:0];
                        overrun_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (reg_we && (reg_addr == REG_CMD)) begin
            overrun_r <= 1'b1;
        end
    end

    // Combinational register readback
    always_comb begin
        reg_rdata = 32'h0;
        case (reg_addr)
            REG_P0:    reg_rdata = p0_r;
            REG_P1:    reg_rdata = p1_r;
            REG_COLOR: reg_rdata = color_r;
            REG_CMD:   reg_rdata = {30'h0, overrun_r, busy_r};
            default:   reg_rdata = 32'h0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = accept_s ? ST_SETUP : ST_IDLE;
            ST_SETUP: begin
                case (cmd_r)
                    CMD_LINE: state_nxt_s = ST_LINE;
                    CMD_RECT: state_nxt_s = ST_RECT;
                    CMD_SWAP: state_nxt_s = ST_SWAP;
                    default:  state_nxt_s = ST_IDLE;
                endcase
            end
            ST_LINE:  state_nxt_s = (advance_s && line_last_s) ? ST_IDLE : ST_LINE;
            ST_RECT:  state_nxt_s = (advance_s && rect_last_s) ? ST_IDLE : ST_RECT;
            ST_SWAP:  state_nxt_s = advance_s ? ST_IDLE : ST_SWAP;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next cursor, walk constants and the registered pixel request
    always_comb begin
        x_nxt_s        = x_r;
        y_nxt_s        = y_r;
        err_nxt_s      = err_r;
        dx_nxt_s       = dx_r;
        dy_nxt_s       = dy_r;
        sx_nxt_s       = sx_r;
        sy_nxt_s       = sy_r;
        xe_nxt_s       = xe_r;
        ye_nxt_s       = ye_r;
        xmin_nxt_s     = xmin_r;
        pix_we_nxt_s   = pix_we_r;
        pix_addr_nxt_s = pix_addr_r;
        pix_data_nxt_s = pix_data_r;
        busy_nxt_s     = busy_r;
        case (state_r)
            ST_IDLE: begin
                pix_we_nxt_s = 1'b0;
                busy_nxt_s   = accept_s;
            end
            ST_SETUP: begin
                pix_data_nxt_s = color_r;
                case (cmd_r)
                    CMD_LINE: begin
                        x_nxt_s        = x0_s;
                        y_nxt_s        = y0_s;
                        dx_nxt_s       = adx_s;
                        dy_nxt_s       = -ady_s;
                        err_nxt_s      = adx_s - ady_s;
                        sx_nxt_s       = (x0_s < x1_s) ? COORD_ONE : COORD_NEG1;
                        sy_nxt_s       = (y0_s < y1_s) ? COORD_ONE : COORD_NEG1;
                        xe_nxt_s       = x1_s;
                        ye_nxt_s       = y1_s;
                        pix_we_nxt_s   = on_screen(x0_s, y0_s);
                        pix_addr_nxt_s = fb_addr(x0_s[9:0], y0_s[9:0]);
                    end
                    CMD_RECT: begin
                        x_nxt_s        = xmin_s;
                        y_nxt_s        = ymin_s;
                        xmin_nxt_s     = xmin_s;
                        xe_nxt_s       = xmax_s;
                        ye_nxt_s       = ymax_s;
                        pix_we_nxt_s   = on_screen(xmin_s, ymin_s);
                        pix_addr_nxt_s = fb_addr(xmin_s[9:0], ymin_s[9:0]);
                    end
                    CMD_SWAP: begin
                        pix_we_nxt_s   = 1'b1;
                        pix_addr_nxt_s = SWAP_ADDR;
                    end
                    default: begin
                        pix_we_nxt_s = 1'b0;
                        busy_nxt_s   = 1'b0;
                    end
                endcase
            end
            ST_LINE: begin
                if (advance_s && line_last_s) begin
                    pix_we_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end else if (advance_s) begin
                    x_nxt_s        = step_x_s;
                    y_nxt_s        = step_y_s;
                    err_nxt_s      = step_err_s;
                    pix_we_nxt_s   = on_screen(step_x_s, step_y_s);
                    pix_addr_nxt_s = fb_addr(step_x_s[9:0], step_y_s[9:0]);
                end else begin
                    pix_we_nxt_s = pix_we_r;
                end
            end
            ST_RECT: begin
                if (advance_s && rect_last_s) begin
                    pix_we_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end else if (advance_s) begin
                    // Row-major scan: wrap to xmin on the next row at xmax
                    x_nxt_s        = (x_r == xe_r) ? xmin_r : (x_r + COORD_ONE);
                    y_nxt_s        = (x_r == xe_r) ? (y_r + COORD_ONE) : y_r;
                    pix_we_nxt_s   = on_screen(x_nxt_s, y_nxt_s);
                    pix_addr_nxt_s = fb_addr(x_nxt_s[9:0], y_nxt_s[9:0]);
                end else begin
                    pix_we_nxt_s = pix_we_r;
                end
            end
            ST_SWAP: begin
                if (advance_s) begin
                    pix_we_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end else begin
                    pix_we_nxt_s = pix_we_r;
                end
            end
            default: begin
                pix_we_nxt_s = 1'b0;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_r        <= COORD_ZERO;
            y_r        <= COORD_ZERO;
            err_r      <= COORD_ZERO;
            dx_r       <= COORD_ZERO;
            dy_r       <= COORD_ZERO;
            sx_r       <= COORD_ZERO;
            sy_r       <= COORD_ZERO;
            xe_r       <= COORD_ZERO;
            ye_r       <= COORD_ZERO;
            xmin_r     <= COORD_ZERO;
            pix_we_r   <= 1'b0;
            pix_addr_r <= 24'h0;
            pix_data_r <= 32'h0;
            busy_r     <= 1'b0;
        end else begin
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            err_r      <= err_nxt_s;
            dx_r       <= dx_nxt_s;
            dy_r       <= dy_nxt_s;
            sx_r       <= sx_nxt_s;
            sy_r       <= sy_nxt_s;
            xe_r       <= xe_nxt_s;
            ye_r       <= ye_nxt_s;
            xmin_r     <= xmin_nxt_s;
            pix_we_r   <= pix_we_nxt_s;
            pix_addr_r <= pix_addr_nxt_s;
            pix_data_r <= pix_data_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign pix_we   = pix_we_r;
    assign pix_addr = pix_addr_r;
    assign pix_data = pix_data_r;
    assign busy     = busy_r;

endmodule
